ofdm_symbol_mapper: RTL

- Streaming OFDM symbol builder. Accepts a byte stream over a valid/ready handshake and maps bits to QAM4 or QAM16 (runtime mode) onto data subcarriers 1..N_DATA. DC and unused bins are zero.
- Buffers one full symbol, then emits all N_FFT bins serially in natural order (0..N_FFT-1) to a streaming FFT/IFFT.
- Generalises the fixed 4-carrier QAM4 byte mapper to parametrised size, modulation and flow control.

---
 rtl/ofdm_symbol_mapper_pkg.sv | 25 ++
 rtl/ofdm_symbol_mapper_qam_mapper.sv | 50 +++++
 rtl/ofdm_symbol_mapper.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ofdm_symbol_mapper_pkg.sv
// Shared types and constellation constants for the OFDM symbol mapper.
// Constants are derived from the fixed-point fraction width at elaboration.
package ofdm_pkg;

  typedef enum logic {
    MODE_QAM4  = 1'b0,
    MODE_QAM16 = 1'b1
  } mode_e;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_e;

  // round(0.7071 * 2^frac)
  function automatic int qam4_amp(input int frac);
    return (7071 * (1 << frac) + 5000) / 10000;
  endfunction

  // round(2^frac / sqrt(10))
  function automatic int qam16_lvl(input int frac);
    return (3162 * (1 << frac) + 5000) / 10000;
  endfunction

endpackage

// File: rtl/ofdm_symbol_mapper_qam_mapper.sv
// Combinational QAM4 / Gray-coded QAM16 point mapper.
// Four input bits in, sign-extended fixed-point re/im out.
module qam_mapper
  import ofdm_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int FRACTION  = 8
) (
  input  logic [3:0]                  bits,
  input  mode_e                       mode,
  output logic signed [WORD_SIZE-1:0] re,
  output logic signed [WORD_SIZE-1:0] im
);

  localparam logic signed [WORD_SIZE-1:0] A =
    WORD_SIZE'(qam4_amp(FRACTION));
  localparam logic signed [WORD_SIZE-1:0] L1 =
    WORD_SIZE'(qam16_lvl(FRACTION));
  localparam logic signed [WORD_SIZE-1:0] L3 =
    WORD_SIZE'(3 * qam16_lvl(FRACTION));

  function automatic logic signed [WORD_SIZE-1:0] gray4(
    input logic [1:0] p
  );
    logic signed [WORD_SIZE-1:0] v;
    unique case (p)
      2'b00:   v = -L3;
      2'b01:   v = -L1;
      2'b11:   v = L1;
      default: v = L3;
    endcase
    return v;
  endfunction

  always_comb begin
    re = '0;
    im = '0;
    unique case (mode)
      MODE_QAM16: begin
        re = gray4(bits[1:0]);
        im = gray4(bits[3:2]);
      end
      default: begin
        re = bits[0] ? -A : A;
        im = bits[1] ? -A : A;
      end
    endcase
  end

endmodule

// File: rtl/ofdm_symbol_mapper.sv
// Streaming OFDM symbol builder: byte stream in, N_FFT bins out.
// Define OFDM_HERMITIAN_EN to mirror conj(data) into the upper bins.
module ofdm_symbol_mapper
  import ofdm_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int FRACTION  = 8,
  parameter int N_FFT     = 32,
  parameter int N_DATA    = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_mode,
  input  logic [7:0]                  i_byte,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic signed [WORD_SIZE-1:0] o_re,
  output logic signed [WORD_SIZE-1:0] o_im,
  output logic [$clog2(N_FFT)-1:0]    o_index,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_sof,
  output logic                        o_eof
);

  localparam int IW    = $clog2(N_FFT);
  localparam int BUF_W = N_DATA * 4;
  localparam int NB16  = N_DATA / 2;
  localparam int NB4   = N_DATA / 4;
  localparam int CW    = $clog2(NB16);
  localparam logic [IW-1:0] LAST = IW'(N_FFT - 1);

  state_e                      state_q, state_d;
  mode_e                       mode_q, mode_d, mode_eff;
  logic                        ready_q, ready_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [BUF_W-1:0]            buf_q, buf_d;
  logic                        valid_q, valid_d;
  logic                        sof_q, sof_d;
  logic                        eof_q, eof_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic signed [WORD_SIZE-1:0] re_q, re_d;
  logic signed [WORD_SIZE-1:0] im_q, im_d;
  logic                        accept, last_byte;

  logic [IW-1:0]               nxt_idx, src_k, src_m1;
  logic [IW+1:0]               sh;
  logic [BUF_W-1:0]            shifted;
  logic [3:0]                  sym_bits;
  logic                        in_band, conj;
  logic signed [WORD_SIZE-1:0] map_re, map_im;
  logic signed [WORD_SIZE-1:0] bin_re, bin_im;

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_sof   = sof_q;
  assign o_eof   = eof_q;
  assign o_index = idx_q;
  assign o_re    = re_q;
  assign o_im    = im_q;

  // Content of the bin that follows the one currently presented.
  always_comb begin
    nxt_idx = idx_q + IW'(1);
    src_k   = '0;
    in_band = 1'b0;
    conj    = 1'b0;
    if (nxt_idx != '0 && nxt_idx <= IW'(N_DATA)) begin
      src_k   = nxt_idx;
      in_band = 1'b1;
    end
`ifdef OFDM_HERMITIAN_EN
    else if (nxt_idx >= IW'(N_FFT - N_DATA)) begin
      src_k   = IW'(N_FFT) - nxt_idx;
      in_band = 1'b1;
      conj    = 1'b1;
    end
`endif
    src_m1 = src_k - IW'(1);
    if (mode_q == MODE_QAM16) sh = {src_m1, 2'b00};
    else                      sh = {1'b0, src_m1, 1'b0};
    shifted = buf_q >> sh;
    if (mode_q == MODE_QAM16) sym_bits = shifted[3:0];
    else                      sym_bits = {2'b00, shifted[1:0]};
    bin_re = in_band ? map_re : '0;
    bin_im = '0;
    if (in_band) bin_im = conj ? -map_im : map_im;
  end

  qam_mapper #(
    .WORD_SIZE (WORD_SIZE),
    .FRACTION  (FRACTION)
  ) u_qam (
    .bits (sym_bits),
    .mode (mode_q),
    .re   (map_re),
    .im   (map_im)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    valid_d  = valid_q;
    sof_d    = sof_q;
    eof_d    = eof_q;
    idx_d    = idx_q;
    re_d     = re_q;
    im_d     = im_q;
    accept   = i_valid & ready_q;
    mode_eff = (cnt_q == '0) ? mode_e'(i_mode) : mode_q;
    if (mode_eff == MODE_QAM16) last_byte = (cnt_q == CW'(NB16 - 1));
    else                        last_byte = (cnt_q == CW'(NB4 - 1));
    unique case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          buf_d[{cnt_q, 3'b000} +: 8] = i_byte;
          mode_d = mode_eff;
          if (last_byte) begin
            state_d = ST_EMIT;
            cnt_d   = '0;
            valid_d = 1'b1;
            sof_d   = 1'b1;
            eof_d   = 1'b0;
            idx_d   = '0;
            re_d    = '0;
            im_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_EMIT: begin
        if (valid_q && i_ready) begin
          if (idx_q == LAST) begin
            state_d = ST_COLLECT;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
            idx_d   = '0;
            re_d    = '0;
            im_d    = '0;
          end else begin
            idx_d = nxt_idx;
            re_d  = bin_re;
            im_d  = bin_im;
            sof_d = 1'b0;
            eof_d = (nxt_idx == LAST);
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
    ready_d = (state_d == ST_COLLECT);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_COLLECT;
      mode_q  <= MODE_QAM4;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      buf_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      idx_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      idx_q   <= idx_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

endmodule
